// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and helpers for the FIFO read-port arbiter.
// State encoding and burst-length clamp live here.
package fifo_rd_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  function automatic logic [31:0] clamp_len(
    input logic [31:0] len,
    input logic [31:0] max_len
  );
    if (len == 32'd0) return 32'd1;
    if (len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first high req at or after ptr.
// Returns one-hot and encoded winner.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id
);

  logic found;
  int   idx;

  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        gnt_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Shares one async-FIFO read port among consumers in round-robin bursts
// and returns each read word tagged with its owner's ID.
module fifo_read_arbiter
  import fifo_rd_arb_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int ID_W      = $clog2(NUM_REQ),
  parameter int BL_W      = $clog2(MAX_BURST+1)
) (
  input  logic                    clk_r,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*BL_W-1:0] burst_len,
  input  logic                    FIFO_empty,
  input  logic [WIDTH-1:0]        rd_data,
  output logic                    rd_en,
  output logic [NUM_REQ-1:0]      grant,
  output logic                    busy,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic [ID_W-1:0]         out_id
);

  state_e             state_q, state_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [BL_W-1:0]    beats_q, beats_d;
  logic [BL_W-1:0]    len_q, len_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               v1_q;
  logic [ID_W-1:0]    id1_q;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [ID_W-1:0]    out_id_q, out_id_d;
  logic               out_valid_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_id;
  logic [BL_W-1:0]    bl_sel;
  logic [ID_W-1:0]    ptr_next;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .ID_W   (ID_W)
  ) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .gnt_id(arb_id)
  );

  assign bl_sel   = burst_len[int'(arb_id)*BL_W +: BL_W];
  assign ptr_next = (owner_q == ID_W'(NUM_REQ-1)) ? '0
                  : owner_q + ID_W'(1);
  assign rd_en    = (state_q == ST_BURST) && req[owner_q]
                  && !FIFO_empty;

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    beats_d = beats_q;
    len_d   = len_q;
    grant_d = grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d = ST_BURST;
          owner_d = arb_id;
          grant_d = arb_gnt;
          beats_d = '0;
          len_d   = BL_W'(clamp_len(32'(bl_sel), 32'(MAX_BURST)));
        end
      end
      ST_BURST: begin
        if (rd_en) begin
          beats_d = beats_q + BL_W'(1);
        end
        // Last beat issued, or the owner withdrew its request
        if ((rd_en && (beats_q + BL_W'(1) == len_q)) || !req[owner_q]) begin
          state_d = ST_IDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    if (v1_q) begin
      out_data_d = rd_data;
      out_id_d   = id1_q;
    end
  end

  always_ff @(posedge clk_r or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= '0;
      ptr_q       <= '0;
      beats_q     <= '0;
      len_q       <= '0;
      grant_q     <= '0;
      v1_q        <= 1'b0;
      id1_q       <= '0;
      out_data_q  <= '0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      beats_q     <= beats_d;
      len_q       <= len_d;
      grant_q     <= grant_d;
      v1_q        <= rd_en;
      id1_q       <= owner_q;
      out_data_q  <= out_data_d;
      out_id_q    <= out_id_d;
      out_valid_q <= v1_q;
    end
  end

  assign grant     = grant_q;
  assign busy      = (state_q == ST_BURST);
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;

endmodule

// File: doc/fifo_read_arbiter.md
# fifo_read_arbiter

Read-side controller that shares the single asynchronous-FIFO read port among `NUM_REQ` consumers in the `clk_r` domain. It grants the port round-robin in bursts and drives the FIFO read enable, honouring `FIFO_empty`. It captures the memory read data and returns each word tagged with the owning requester's ID. It sits between the consumers and the FIFO's read-pointer logic / dual-port memory.

## Interface
- `WIDTH`, 32, data word width
- `NUM_REQ`, 4, number of consumers (≥2)
- `MAX_BURST`, 4, maximum words per grant (≥1)
- `ID_W`, `$clog2(NUM_REQ)`, requester ID width
- `BL_W`, `$clog2(MAX_BURST+1)`, burst-length field width

Ports. Reset is `reset`, asynchronous, active-high; clock is `clk_r`.
- `clk_r`  in  1  read-domain clock
- `reset`  in  1  async active-high reset
- `req`  in  NUM_REQ  per-consumer read request, level
- `burst_len`  in  NUM_REQ*BL_W  per-consumer burst length, field i at [i*BL_W +: BL_W]
- `FIFO_empty`  in  1  FIFO empty flag, read domain
- `rd_data`  in  WIDTH  memory read data, valid the cycle after `rd_en`
- `rd_en`  out  1  read strobe to the FIFO read-pointer logic
- `grant`  out  NUM_REQ  one-hot current owner, registered
- `busy`  out  1  high in BURST
- `out_data`  out  WIDTH  registered returned word
- `out_valid`  out  1  `out_data` valid, one-cycle pulse per word
- `out_id`  out  ID_W  owner of `out_data`

## Operation
- States:
  - IDLE: no owner.
  - BURST: `grant` holds the owner.
- IDLE → BURST when any `req` is high. Winner is the first high `req` searching `ptr, ptr+1, …` mod NUM_REQ.
  - On this transition: latch owner, `beats` = 0, `len` = `burst_len[owner]`.
  - A `burst_len` field of 0 or greater than MAX_BURST is clamped into 1..MAX_BURST (0→1, >MAX→MAX).
- In BURST: `rd_en = req[owner] && !FIFO_empty`, combinational from registered state. Each `rd_en` increments `beats`.
- BURST → IDLE when either:
  - `rd_en` is high and `beats+1 == len` (last beat), or
  - `req[owner]` is low (no read issued that cycle).
- On every BURST exit, `ptr` ← owner+1 mod NUM_REQ.
- `FIFO_empty` high in BURST: stall. No `rd_en`; state, owner and `beats` are held. There is no timeout.
- `rd_en` is never high in IDLE. `rd_en` is never high when `FIFO_empty` is high.
- Data return pipeline:
  - `v1`, `id1` register `rd_en` and owner.
  - When `v1` is high: `out_data` ← `rd_data`, `out_id` ← `id1`, `out_valid` ← 1.
  - Otherwise `out_valid` ← 0 and `out_data`/`out_id` hold.
- Return order is issue order. Words of consecutive bursts never interleave.

## Timing
- Reset values: state IDLE, `ptr` 0, `grant` 0, `busy` 0, `rd_en` 0, `out_valid` 0, `out_data` 0, `out_id` 0, `v1` 0.
- Arbitration: `req` seen high in IDLE at cycle T → `grant`/`busy` high at T+1. The first `rd_en` can be at T+1.
- Read latency: `rd_en` at cycle T → `rd_data` at T+1 → `out_valid` at T+2.
- Throughput: one word per cycle within a burst. There is exactly one IDLE cycle between bursts.
- A burst's in-flight words still emerge on `out_valid` after `grant` drops.
- Reset mid-burst: everything returns to reset values immediately. In-flight words are discarded; no `out_valid` follows reset.

## Structure
- Shared package `fifo_rd_arb_pkg` holds:
  - state encodings `ST_IDLE` = 0 and `ST_BURST` = 1;
  - the clamp rule for burst length as a function.
- Sub-module `rr_arbiter` is combinational: inputs `req` and `ptr`, outputs one-hot `gnt` and encoded `gnt_id`. It is instantiated once and reused by the bench for its reference model.

## Test plan
- `req` = 0001, `burst_len[0]` = 3, FIFO non-empty → `rd_en` high for 3 consecutive cycles starting T+1, then IDLE. `out_valid` pulses at T+3..T+5 with `out_id` = 0 and data in FIFO order.
- `req` = 0101, all lengths 2, `ptr` = 0 → grant order 0, 2, 0, 2. One idle cycle between bursts; `out_id` sequence 0,0,2,2,0,0.
- Requester 1 in burst, len 4, `FIFO_empty` high after beat 2 for 5 cycles → `rd_en` low for those 5 cycles, `grant` stays 0010, then beats 3 and 4 issue. Exactly 4 `out_valid` pulses.
- Requester 3 len 4 drops `req` after beat 1 → IDLE next cycle; `ptr` = 0; only 1 `out_valid`.
- `burst_len` = 0 → one beat. `burst_len` = 7 with MAX_BURST = 4 → four beats.
- `reset` asserted the cycle after a `rd_en` → all outputs 0 immediately, no `out_valid` after release. The next grant goes to the lowest-index requester that is asserting `req`.
